// File: rtl/rpn_defs.sv
// rpn_defs: shared state codes, display-select codes and default widths for the RPN controller
package rpn_defs;
  typedef enum logic [2:0] {
    CARREGA_A  = 3'd0,
    CARREGA_B  = 3'd1,
    CARREGA_OP = 3'd2,
    CALCULA    = 3'd3,
    MOSTRA     = 3'd4,
    ERRO       = 3'd5
  } estado_t;
  localparam logic [1:0] DISP_CHAVES    = 2'b00;
  localparam logic [1:0] DISP_RESULTADO = 2'b01;
  localparam logic [1:0] DISP_ERRO      = 2'b10;
  localparam int CONT_W_PADRAO = 8;
endpackage

// File: rtl/condicionador_botao.sv
// condicionador_botao: synchronizes, debounces and edge-detects one active-low push-button
// Ports: clk, reset (sync, active-high); i_botao_n raw active-low key; o_pulso one-cycle press pulse.
module condicionador_botao #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_botao_n,
  output logic o_pulso
);
  localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [W-1:0] LIMITE = W'(DEBOUNCE_CYCLES - 1);
  logic r_s1, r_s2, r_nivel, r_nivel_ant;
  logic [W-1:0] r_cnt;
  logic w_difere;
  assign w_difere = r_s2 != r_nivel;
  always_ff @(posedge clk)
    if (reset) begin
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_nivel     <= 1'b0;
      r_nivel_ant <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_s1        <= ~i_botao_n;
      r_s2        <= r_s1;
      r_nivel_ant <= r_nivel;
      // any cycle where the synced level agrees with the filtered one restarts the count
      r_cnt       <= (!w_difere || r_cnt == LIMITE) ? '0 : r_cnt + 1'b1;
      if (w_difere && r_cnt == LIMITE) r_nivel <= r_s2;
    end
  assign o_pulso = r_nivel & ~r_nivel_ant;
endmodule

// File: rtl/controlador_rpn_sequencial.sv
// controlador_rpn_sequencial: button-driven FSM sequencing the A/B/Op/Result registers of the RPN ALU
// Ports: clk, reset (sync, active-high); botao_acao_n/botao_cancela_n raw keys; alu_erro ALU error flag;
// enable_reg_*/limpa_regs one-cycle datapath strobes; sel_A_resultado chaining select;
// estado, sel_display, led_erro status; contagem_ops completed-operation counter.
module controlador_rpn_sequencial
  import rpn_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CONT_W          = CONT_W_PADRAO
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              botao_acao_n,
  input  logic              botao_cancela_n,
  input  logic              alu_erro,
  output logic              enable_reg_A,
  output logic              sel_A_resultado,
  output logic              enable_reg_B,
  output logic              enable_reg_Op,
  output logic              enable_reg_Resultado,
  output logic              limpa_regs,
  output logic [2:0]        estado,
  output logic [1:0]        sel_display,
  output logic              led_erro,
  output logic [CONT_W-1:0] contagem_ops
);
  estado_t r_estado, w_prox;
  logic [CONT_W-1:0] r_cont;
  logic w_acao_p, w_cancela_p;
  condicionador_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_acao (
    .clk(clk), .reset(reset), .i_botao_n(botao_acao_n), .o_pulso(w_acao_p)
  );
  condicionador_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancela (
    .clk(clk), .reset(reset), .i_botao_n(botao_cancela_n), .o_pulso(w_cancela_p)
  );
  always_ff @(posedge clk)
    if (reset) begin
      r_estado <= CARREGA_A;
      r_cont   <= '0;
    end else begin
      r_estado <= w_prox;
      if (enable_reg_Resultado) r_cont <= r_cont + 1'b1;
    end
  always_comb begin
    w_prox               = r_estado;
    enable_reg_A         = 1'b0;
    sel_A_resultado      = 1'b0;
    enable_reg_B         = 1'b0;
    enable_reg_Op        = 1'b0;
    enable_reg_Resultado = 1'b0;
    limpa_regs           = 1'b0;
    case (r_estado)
      CARREGA_A: if (w_acao_p) begin
        enable_reg_A = 1'b1;
        w_prox       = CARREGA_B;
      end
      CARREGA_B: if (w_acao_p) begin
        enable_reg_B = 1'b1;
        w_prox       = CARREGA_OP;
      end
      CARREGA_OP: if (w_acao_p) begin
        enable_reg_Op = 1'b1;
        w_prox        = CALCULA;
      end
      CALCULA: begin
        enable_reg_Resultado = ~alu_erro;
        w_prox               = alu_erro ? ERRO : MOSTRA;
      end
      MOSTRA: if (w_acao_p) begin
        enable_reg_A    = 1'b1;
        sel_A_resultado = 1'b1;
        w_prox          = CARREGA_B;
      end
      ERRO: if (w_acao_p) begin
        limpa_regs = 1'b1;
        w_prox     = CARREGA_A;
      end
      default: w_prox = CARREGA_A;
    endcase
    // cancel overrides everything, but illegal codes keep all outputs low
    if (w_cancela_p && r_estado <= ERRO) begin
      enable_reg_A         = 1'b0;
      sel_A_resultado      = 1'b0;
      enable_reg_B         = 1'b0;
      enable_reg_Op        = 1'b0;
      enable_reg_Resultado = 1'b0;
      limpa_regs           = 1'b1;
      w_prox               = CARREGA_A;
    end
  end
  assign sel_display  = r_estado == MOSTRA ? DISP_RESULTADO : r_estado == ERRO ? DISP_ERRO : DISP_CHAVES;
  assign led_erro     = r_estado == ERRO;
  assign estado       = r_estado;
  assign contagem_ops = r_cont;
endmodule

// File: tb/tb_controlador_rpn_sequencial.sv
// tb_controlador_rpn_sequencial: scoreboard bench for the RPN controller against an output-change model
module tb_controlador_rpn_sequencial;
  localparam int D = 4;
  localparam logic [5:0] P_NADA  = 6'b000000;
  localparam logic [5:0] P_A     = 6'b100000;
  localparam logic [5:0] P_CHAIN = 6'b110000;
  localparam logic [5:0] P_B     = 6'b001000;
  localparam logic [5:0] P_OP    = 6'b000100;
  localparam logic [5:0] P_RES   = 6'b000010;
  localparam logic [5:0] P_LIMPA = 6'b000001;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic botao_acao_n = 1'b1;
  logic botao_cancela_n = 1'b1;
  logic alu_erro = 1'b0;
  logic enable_reg_A, sel_A_resultado, enable_reg_B, enable_reg_Op, enable_reg_Resultado, limpa_regs;
  logic [2:0] estado;
  logic [1:0] sel_display;
  logic led_erro;
  logic [7:0] contagem_ops;
  controlador_rpn_sequencial #(.DEBOUNCE_CYCLES(D), .CONT_W(8)) dut (
    .clk(clk), .reset(reset), .botao_acao_n(botao_acao_n), .botao_cancela_n(botao_cancela_n),
    .alu_erro(alu_erro), .enable_reg_A(enable_reg_A), .sel_A_resultado(sel_A_resultado),
    .enable_reg_B(enable_reg_B), .enable_reg_Op(enable_reg_Op),
    .enable_reg_Resultado(enable_reg_Resultado), .limpa_regs(limpa_regs), .estado(estado),
    .sel_display(sel_display), .led_erro(led_erro), .contagem_ops(contagem_ops)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [19:0] q[$];
  logic [19:0] prev, snap, e;
  bit mon_en = 1'b0;
  int m_st = 0;
  int m_cnt = 0;
  int ops = 0;
  function automatic logic [19:0] mk(input logic [5:0] p, input int st, input int cnt);
    logic [1:0] sd;
    sd = st == 4 ? 2'b01 : st == 5 ? 2'b10 : 2'b00;
    return {p, 3'(st), sd, st == 5 ? 1'b1 : 1'b0, 8'(cnt)};
  endfunction
  function automatic logic [19:0] dut_snap();
    return {enable_reg_A, sel_A_resultado, enable_reg_B, enable_reg_Op, enable_reg_Resultado,
            limpa_regs, estado, sel_display, led_erro, contagem_ops};
  endfunction
  task automatic check(input string nome, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nome, act, exp);
    end
  endtask
  task automatic model_acao(input bit err);
    case (m_st)
      0: begin q.push_back(mk(P_A, 0, m_cnt)); m_st = 1; end
      1: begin q.push_back(mk(P_B, 1, m_cnt)); m_st = 2; end
      2: begin
        q.push_back(mk(P_OP, 2, m_cnt));
        if (err) begin
          q.push_back(mk(P_NADA, 3, m_cnt));
          m_st = 5;
        end else begin
          q.push_back(mk(P_RES, 3, m_cnt));
          m_cnt = (m_cnt + 1) % 256;
          ops++;
          m_st = 4;
        end
      end
      4: begin q.push_back(mk(P_CHAIN, 4, m_cnt)); m_st = 1; end
      5: begin q.push_back(mk(P_LIMPA, 5, m_cnt)); m_st = 0; end
      default: ;
    endcase
    q.push_back(mk(P_NADA, m_st, m_cnt));
  endtask
  task automatic model_cancela();
    q.push_back(mk(P_LIMPA, m_st, m_cnt));
    m_st = 0;
    q.push_back(mk(P_NADA, 0, m_cnt));
  endtask
  task automatic drain();
    @(negedge clk);
    check("scoreboard drain", q.size(), 0);
    q.delete();
  endtask
  task automatic press(input bit a, input bit c, input bit err);
    if (c) model_cancela();
    else model_acao(err);
    alu_erro = err;
    @(posedge clk); #1;
    botao_acao_n = ~a;
    botao_cancela_n = ~c;
    repeat (D + 4) @(posedge clk);
    #1;
    botao_acao_n = 1'b1;
    botao_cancela_n = 1'b1;
    repeat (D + 4) @(posedge clk);
    drain();
  endtask
  initial begin
    int lat;
    int iter;
    logic [2:0] antigo;
    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          snap = dut_snap();
          if (snap !== prev) begin
            checks++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL unexpected output change: got %h expected none (prev %h)", snap, prev);
            end else begin
              e = q.pop_front();
              if (snap !== e) begin
                errors++;
                $display("FAIL scoreboard: got %h expected %h", snap, e);
              end
            end
            prev = snap;
          end
        end
      end
      begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
      end
    join_none
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset snapshot", 32'(dut_snap()), 32'(mk(P_NADA, 0, 0)));
    prev = mk(P_NADA, 0, 0);
    mon_en = 1'b1;
    // full sequence
    repeat (3) press(1'b1, 1'b0, 1'b0);
    check("full estado", estado, 4);
    check("full sel_display", sel_display, 1);
    check("full contagem", contagem_ops, 1);
    // bounce then settle: one chaining pulse, state moves on the 7th edge
    model_acao(1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      botao_acao_n = i[0];
      repeat (2) @(posedge clk);
      #1;
    end
    check("bounce no pulse", estado, 4);
    antigo = estado;
    botao_acao_n = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (estado != antigo) begin
        lat = i;
        break;
      end
    end
    check("press latency", lat, 7);
    repeat (D + 4) @(posedge clk);
    #1 botao_acao_n = 1'b1;
    repeat (D + 4) @(posedge clk);
    drain();
    check("chain estado", estado, 1);
    // chaining second result
    repeat (2) press(1'b1, 1'b0, 1'b0);
    check("chain contagem", contagem_ops, 2);
    // error path
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b1);
    check("erro estado", estado, 5);
    check("erro led", led_erro, 1);
    check("erro sel_display", sel_display, 2);
    check("erro contagem", contagem_ops, 2);
    press(1'b1, 1'b0, 1'b0);
    check("erro exit estado", estado, 0);
    // cancel priority in CARREGA_OP
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    check("cancel estado", estado, 0);
    check("cancel keeps contagem", contagem_ops, 2);
    // reset in CARREGA_B with the action key held through it
    press(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    mon_en = 1'b0;
    reset = 1'b1;
    botao_acao_n = 1'b0;
    @(posedge clk); #1;
    check("reset in B snapshot", 32'(dut_snap()), 32'(mk(P_NADA, 0, 0)));
    reset = 1'b0;
    q.delete();
    m_st = 0;
    m_cnt = 0;
    ops = 0;
    prev = mk(P_NADA, 0, 0);
    mon_en = 1'b1;
    model_acao(1'b0);
    repeat (D + 6) @(posedge clk);
    #1 botao_acao_n = 1'b1;
    repeat (D + 4) @(posedge clk);
    drain();
    // randomized traffic until the counter has wrapped
    iter = 0;
    while (ops < 260 && iter < 2500) begin
      int r;
      r = $urandom_range(0, 9);
      press(r != 0, r == 0, m_st == 2 && $urandom_range(0, 7) == 0);
      iter++;
    end
    check("random ops reached", ops >= 260 ? 1 : 0, 1);
    check("wrap contagem", contagem_ops, ops % 256);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
